moore_pattern_tx: RTL

//  Serial frame transmitter: the sending end of the single-wire "101"-sync link.

---
 rtl/moore_pattern_tx_pkg.sv | 23 ++
 rtl/moore_pattern_tx_if.sv | 11 +
 rtl/moore_pattern_tx_bit_cnt.sv | 37 +++
 rtl/moore_pattern_tx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/moore_pattern_tx_pkg.sv
// Shared types and constants for the "101"-sync serial frame transmitter.
package ptx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [2:0] SYNC_PAT = 3'b101;
  localparam int         SYNC_LEN = 3;

  // Bit counter width: wide enough for the longest of sync, data and gap.
  function automatic int cnt_width(input int data_w, input int gap_len);
    int m;
    m = (data_w > gap_len) ? data_w : gap_len;
    if (m < SYNC_LEN) m = SYNC_LEN;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/moore_pattern_tx_if.sv
// Parallel-word valid/ready handshake into the serial frame transmitter.
interface moore_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/moore_pattern_tx_bit_cnt.sv
// Loadable down-counter with zero flag; paces the sync, data and gap phases.
module ptx_bit_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Never wraps: holds at zero until the next state entry reloads it.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt = cnt_d;
  assign zero    = (cnt_q == '0);

endmodule

// File: rtl/moore_pattern_tx.sv
// Serial "101"-sync frame transmitter: sync, data MSB-first, optional even
// parity (macro PATTERN_TX_PARITY_EN), then a forced-zero gap.
module moore_pattern_tx
  import ptx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic                clk,
  input  logic                rst,
  moore_pattern_tx_if.slave   in_if,
  output logic                out,
  output logic                out_en,
  output logic                busy
);

  localparam int CNT_W = cnt_width(DATA_W, GAP_LEN);
  // Sync pattern widened so it can be indexed directly by the counter.
  localparam logic [2**CNT_W-1:0] SYNC_PAT_W = {{(2**CNT_W-3){1'b0}}, SYNC_PAT};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              out_q, out_d;
  logic              out_en_q, out_en_d;
  logic              accept;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              cnt_zero;

`ifdef PATTERN_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign in_if.in_ready = (state_q == IDLE) && !rst;
  assign accept         = in_if.in_valid && in_if.in_ready;

  ptx_bit_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt_nxt  (cnt_nxt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = SYNC;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(SYNC_LEN - 1);
          shreg_d      = in_if.in_data;
`ifdef PATTERN_TX_PARITY_EN
          par_d        = ^in_if.in_data;
`endif
        end
      end
      SYNC: begin
        if (cnt_zero) begin
          state_d      = DATA;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(DATA_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
`ifdef PATTERN_TX_PARITY_EN
          state_d      = PAR;
`else
          state_d      = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(GAP_LEN - 1);
`endif
        end else begin
          cnt_dec = 1'b1;
          shreg_d = shreg_q << 1;
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      PAR: begin
        state_d      = GAP;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(GAP_LEN - 1);
      end
`endif
      GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register is loaded from the next state, so out always reflects state_q.
  always_comb begin
    out_d    = 1'b0;
    out_en_d = 1'b0;
    case (state_d)
      SYNC: begin
        out_d    = SYNC_PAT_W[cnt_nxt];
        out_en_d = 1'b1;
      end
      DATA: begin
        out_d    = shreg_d[DATA_W-1];
        out_en_d = 1'b1;
      end
`ifdef PATTERN_TX_PARITY_EN
      PAR: begin
        out_d    = par_q;
        out_en_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      out_q    <= 1'b0;
      out_en_q <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      out_q    <= out_d;
      out_en_q <= out_en_d;
`ifdef PATTERN_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign out    = out_q;
  assign out_en = out_en_q;
  assign busy   = (state_q != IDLE);

endmodule
